// File: rtl/sprite_line_engine_if.sv
// Request, result and store-write signals of the sprite line engine.
// master = renderer / host side, slave = sprite_line_engine.
interface sprite_line_engine_if #(
    parameter int SPRITE_W = 8,
    parameter int ID_W     = 4,
    parameter int LINE_W   = $clog2(SPRITE_W)
);
    logic                req_valid;
    logic                req_ready;
    logic [ID_W-1:0]     req_sprite;
    logic [LINE_W-1:0]   req_line;
    logic [2:0]          req_orient;

    logic                out_valid;
    logic                out_ready;
    logic [SPRITE_W-1:0] line_data;

    logic                wr_en;
    logic [ID_W-1:0]     wr_sprite;
    logic [LINE_W-1:0]   wr_row;
    logic [SPRITE_W-1:0] wr_data;

    modport master (
        output req_valid, req_sprite, req_line, req_orient, out_ready,
               wr_en, wr_sprite, wr_row, wr_data,
        input  req_ready, out_valid, line_data
    );

    modport slave (
        input  req_valid, req_sprite, req_line, req_orient, out_ready,
               wr_en, wr_sprite, wr_row, wr_data,
        output req_ready, out_valid, line_data
    );
endinterface

// File: rtl/sprite_line_engine.sv
// Sprite line fetcher: returns one displayed line of a stored 1-bpp
// active-low sprite in any of 8 orientations.
//
// state  | meaning
// IDLE   | accepts requests; rot0/rot180 lines are produced directly from one row
// GATHER | rot90/rot270: one store row per cycle supplies one pixel of the line
//
// The store has a single port and writes always win it, so a write stalls
// a gather step. Since N-x equals ~x for a power-of-2 edge, all mirrored
// and reversed indices are plain bit inversions.
module sprite_line_engine #(
    parameter int SPRITE_W    = 8,
    parameter int NUM_SPRITES = 16,
    parameter int ID_W        = 4,
    parameter int LINE_W      = $clog2(SPRITE_W)
) (
    input  logic                   clk,
    input  logic                   reset,
    sprite_line_engine_if.slave    bus,
    output logic                   busy
);
    localparam logic [LINE_W-1:0] LAST = LINE_W'(SPRITE_W - 1);

    typedef enum logic {IDLE, GATHER} state_t;

    state_t              state, state_nxt;
    logic [SPRITE_W-1:0] mem [NUM_SPRITES][SPRITE_W];
    logic [LINE_W-1:0]   cnt;
    logic [ID_W-1:0]     g_sprite;
    logic [LINE_W-1:0]   g_line;
    logic [2:0]          g_orient;
    logic [SPRITE_W-1:0] acc, acc_nxt, direct_line, rd_word;
    logic [ID_W-1:0]     rd_sprite;
    logic [LINE_W-1:0]   rd_row, direct_sy, d_xm, d_sx, g_bit, g_xm, g_x;
    logic                accept, step, done, direct_load;

    assign bus.req_ready = (state == IDLE) & ~bus.wr_en & (~bus.out_valid | bus.out_ready);
    assign busy          = (state == GATHER);
    assign accept        = bus.req_valid & bus.req_ready;
    assign direct_load   = accept & ~bus.req_orient[0];
    assign step          = (state == GATHER) & ~bus.wr_en;
    assign done          = step & (cnt == LAST);

    // Select the store row to read: the mapped row in IDLE, row cnt in GATHER.
    always_comb begin
        direct_sy = bus.req_orient[1] ? ~bus.req_line : bus.req_line;
        rd_sprite = bus.req_sprite;
        rd_row    = direct_sy;
        if (state == GATHER) begin
            rd_sprite = g_sprite;
            rd_row    = cnt;
        end
        rd_word = '1;
        if (int'(rd_sprite) < NUM_SPRITES) begin
            rd_word = mem[rd_sprite][rd_row];
        end
    end

    // rot0/rot180 line: every displayed column comes from the same source row.
    always_comb begin
        direct_line = '1;
        d_xm        = '0;
        d_sx        = '0;
        for (int x = 0; x < SPRITE_W; x++) begin
            d_xm           = bus.req_orient[2] ? ~LINE_W'(x) : LINE_W'(x);
            d_sx           = bus.req_orient[1] ? ~d_xm : d_xm;
            direct_line[x] = rd_word[~d_sx];
        end
    end

    // rot90/rot270: row cnt holds exactly one pixel of the requested line.
    always_comb begin
        g_bit   = g_orient[1] ? g_line : ~g_line;
        g_xm    = g_orient[1] ? cnt : ~cnt;
        g_x     = g_orient[2] ? ~g_xm : g_xm;
        acc_nxt = acc;
        acc_nxt[g_x] = rd_word[g_bit];
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (accept && bus.req_orient[0]) state_nxt = GATHER;
            GATHER: if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gather context, accumulator and output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt           <= '0;
            g_sprite      <= '0;
            g_line        <= '0;
            g_orient      <= '0;
            acc           <= '1;
            bus.line_data <= '1;
            bus.out_valid <= 1'b0;
        end else begin
            if (accept && bus.req_orient[0]) begin
                g_sprite <= bus.req_sprite;
                g_line   <= bus.req_line;
                g_orient <= bus.req_orient;
                cnt      <= '0;
                acc      <= '1;
            end else if (step) begin
                cnt <= cnt + LINE_W'(1);
                acc <= acc_nxt;
            end

            if (direct_load) begin
                bus.line_data <= direct_line;
                bus.out_valid <= 1'b1;
            end else if (done) begin
                bus.line_data <= acc_nxt;
                bus.out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

    // Sprite store; writes to nonexistent sprites are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_SPRITES; s++) begin
                for (int r = 0; r < SPRITE_W; r++) begin
                    mem[s][r] <= '1;
                end
            end
        end else if (bus.wr_en && (int'(bus.wr_sprite) < NUM_SPRITES)) begin
            mem[bus.wr_sprite][bus.wr_row] <= bus.wr_data;
        end
    end
endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench for sprite_line_engine (8x8 sprites, 9 stored).
module tb_sprite_line_engine;
    localparam int SW = 8;
    localparam int NS = 9;
    localparam int IW = 4;
    localparam int LW = 3;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sprite_line_engine_if #(.SPRITE_W(SW), .ID_W(IW), .LINE_W(LW)) bus ();

    sprite_line_engine #(.SPRITE_W(SW), .NUM_SPRITES(NS), .ID_W(IW), .LINE_W(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    typedef struct {
        logic [3:0] spr;
        logic [2:0] line;
        logic [2:0] orient;
        logic [7:0] exp_data;
        int         exp_lat;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_row(input logic [3:0] s, input logic [2:0] r, input logic [7:0] d);
        @(negedge clk);
        bus.wr_en     = 1'b1;
        bus.wr_sprite = s;
        bus.wr_row    = r;
        bus.wr_data   = d;
        @(posedge clk);
        #1 bus.wr_en = 1'b0;
    endtask

    // Issue one request; lat = edges after the accept edge until out_valid.
    task automatic do_req(input logic [3:0] s, input logic [2:0] l, input logic [2:0] o,
                          output logic [7:0] data, output int lat, output int busy_n);
        int guard;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_sprite = s;
        bus.req_line   = l;
        bus.req_orient = o;
        #1;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("req_ready_before_accept", bus.req_ready, 1);
        lat    = -1;
        busy_n = 0;
        data   = 8'hxx;
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) bus.req_valid = 1'b0;
            if (busy) busy_n++;
            if (bus.out_valid) begin
                lat  = k;
                data = bus.line_data;
                break;
            end
        end
    endtask

    // Watchdog.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] data;
        int         lat, busy_n;
        logic [7:0] s0_rows [8];

        s0_rows = '{8'hC7, 8'h83, 8'h81, 8'hC0, 8'hC8, 8'h91, 8'h83, 8'hC7};

        vecs[0]  = '{4'd0,  3'd3, 3'd0, 8'h03, 0};
        vecs[1]  = '{4'd0,  3'd3, 3'd4, 8'hC0, 0};
        vecs[2]  = '{4'd0,  3'd0, 3'd0, 8'hE3, 0};
        vecs[3]  = '{4'd0,  3'd0, 3'd4, 8'hC7, 0};
        vecs[4]  = '{4'd0,  3'd4, 3'd2, 8'hC0, 0};
        vecs[5]  = '{4'd0,  3'd7, 3'd1, 8'hE7, 8};
        vecs[6]  = '{4'd0,  3'd5, 3'd3, 8'h00, 8};
        vecs[7]  = '{4'd2,  3'd1, 3'd1, 8'hBF, 8};
        vecs[8]  = '{4'd2,  3'd6, 3'd3, 8'hFD, 8};
        vecs[9]  = '{4'd2,  3'd6, 3'd2, 8'hBF, 0};
        vecs[10] = '{4'd2,  3'd1, 3'd5, 8'hFD, 8};
        vecs[11] = '{4'd2,  3'd6, 3'd7, 8'hBF, 8};
        vecs[12] = '{4'd2,  3'd6, 3'd6, 8'hFD, 0};
        vecs[13] = '{4'd15, 3'd0, 3'd0, 8'hFF, 0};
        vecs[14] = '{4'd15, 3'd2, 3'd1, 8'hFF, 8};

        reset          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_sprite = '0;
        bus.req_line   = '0;
        bus.req_orient = '0;
        bus.out_ready  = 1'b1;
        bus.wr_en      = 1'b0;
        bus.wr_sprite  = '0;
        bus.wr_row     = '0;
        bus.wr_data    = '0;

        repeat (2) @(negedge clk);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_line_data", bus.line_data, 8'hFF);
        check("reset_busy", busy, 0);
        reset = 1'b1;
        #1 check("reset_req_ready", bus.req_ready, 1);

        for (int r = 0; r < 8; r++) write_row(4'd0, 3'(r), s0_rows[r]);

        // Write in IDLE with a request pending: request must be held off.
        @(negedge clk);
        bus.wr_en      = 1'b1;
        bus.wr_sprite  = 4'd2;
        bus.wr_row     = 3'd1;
        bus.wr_data    = 8'hBF;
        bus.req_valid  = 1'b1;
        bus.req_sprite = 4'd0;
        bus.req_line   = 3'd0;
        bus.req_orient = 3'd0;
        #1 check("wr_blocks_req_ready", bus.req_ready, 0);
        @(posedge clk);
        #1;
        bus.wr_en     = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("wr_blocked_no_output", bus.out_valid, 0);

        for (int i = 0; i < 15; i++) begin
            do_req(vecs[i].spr, vecs[i].line, vecs[i].orient, data, lat, busy_n);
            check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_busy_cycles", i), busy_n, vecs[i].exp_lat);
        end

        // Backpressure: result held, next request waits, then accepted on release.
        @(negedge clk);
        bus.out_ready  = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_sprite = 4'd0;
        bus.req_line   = 3'd3;
        bus.req_orient = 3'd0;
        @(posedge clk);
        @(negedge clk);
        bus.req_line = 3'd0;
        #1;
        check("bp_valid", bus.out_valid, 1);
        check("bp_data", bus.line_data, 8'h03);
        check("bp_req_ready", bus.req_ready, 0);
        repeat (3) @(negedge clk);
        check("bp_hold_valid", bus.out_valid, 1);
        check("bp_hold_data", bus.line_data, 8'h03);
        bus.out_ready = 1'b1;
        #1 check("bp_release_req_ready", bus.req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("bp_next_valid", bus.out_valid, 1);
        check("bp_next_data", bus.line_data, 8'hE3);

        // Write collision: two stalling writes to rows not yet gathered.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_sprite = 4'd2;
        bus.req_line   = 3'd1;
        bus.req_orient = 3'd1;
        #1 check("col_req_ready", bus.req_ready, 1);
        @(posedge clk);
        lat    = -1;
        busy_n = 0;
        data   = 8'hxx;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) bus.req_valid = 1'b0;
            if (busy) busy_n++;
            if (bus.out_valid) begin
                lat  = k;
                data = bus.line_data;
                break;
            end
            if (k == 1 || k == 2) begin
                bus.wr_en     = 1'b1;
                bus.wr_sprite = 4'd2;
                bus.wr_row    = (k == 1) ? 3'd6 : 3'd7;
                bus.wr_data   = 8'h00;
            end else begin
                bus.wr_en = 1'b0;
            end
        end
        bus.wr_en = 1'b0;
        check("col_data", data, 8'hBC);
        check("col_latency", lat, 10);
        check("col_busy_cycles", busy_n, 10);

        // Out-of-range write must not alias onto a stored sprite.
        write_row(4'd15, 3'd3, 8'h00);
        write_row(4'd9, 3'd3, 8'h00);
        do_req(4'd0, 3'd3, 3'd0, data, lat, busy_n);
        check("oor_write_s0_row3", data, 8'h03);
        do_req(4'd0, 3'd5, 3'd3, data, lat, busy_n);
        check("oor_write_s0_col", data, 8'h00);

        // Reset in the middle of a gather.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_sprite = 4'd0;
        bus.req_line   = 3'd7;
        bus.req_orient = 3'd1;
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) bus.req_valid = 1'b0;
        end
        check("mid_busy_before_reset", busy, 1);
        reset = 1'b0;
        #1;
        check("mid_reset_out_valid", bus.out_valid, 0);
        check("mid_reset_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_reset_no_output", bus.out_valid, 0);
        do_req(4'd0, 3'd3, 3'd0, data, lat, busy_n);
        check("post_reset_row_data", data, 8'hFF);
        check("post_reset_row_latency", lat, 0);
        do_req(4'd0, 3'd7, 3'd1, data, lat, busy_n);
        check("post_reset_gather_data", data, 8'hFF);
        check("post_reset_gather_latency", lat, 8);
        do_req(4'd2, 3'd6, 3'd2, data, lat, busy_n);
        check("post_reset_s2_data", data, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sprite_line_engine.md
# sprite_line_engine

Parametrised sprite line fetcher for the TinyTapeStation pixel pipeline. It holds NUM_SPRITES square SPRITE_W×SPRITE_W 1-bpp active-low bitmaps in a writable register store. It returns one display line per request in any of 8 orientations (4 rotations × optional mirror). Requests and results use valid/ready handshakes, so the tile/sprite renderer can stall it.

## Interface
Parameters:
- SPRITE_W, 8, sprite edge in pixels; power of 2, ≥2
- NUM_SPRITES, 16, sprites stored; ≤ 2^ID_W
- ID_W, 4, sprite ID width
- LINE_W, $clog2(SPRITE_W), line/row index width

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  line request present
- req_ready  out  1  request accepted on edge where valid&ready
- req_sprite  in  ID_W  sprite ID
- req_line  in  LINE_W  displayed line y (0 = top)
- req_orient  in  3  [1:0] rotation clockwise (0=0°, 1=90°, 2=180°, 3=270°); [2] horizontal mirror
- out_valid  out  1  line_data valid
- out_ready  in  1  consumer takes line_data on edge where valid&ready
- line_data  out  SPRITE_W  bit c = displayed column c (0 = leftmost); 0 = pixel on, 1 = off
- wr_en  in  1  store write strobe
- wr_sprite  in  ID_W  target sprite
- wr_row  in  LINE_W  target row
- wr_data  in  SPRITE_W  row word; MSB = leftmost column; 0 = pixel on
- busy  out  1  high in GATHER

## Operation
- Store: mem[s][r]. Source pixel (sx,sy) = mem[s][sy][N−sx], with N = SPRITE_W−1. Write on edge when wr_en; out-of-range wr_sprite is ignored.
- Mapping for displayed pixel (x,y): if orient[2], replace x by N−x first. Then:
  - rot0: sx=x, sy=y
  - rot90: sx=y, sy=N−x
  - rot180: sx=N−x, sy=N−y
  - rot270: sx=N−y, sy=x
- req_ready = (state==IDLE) & ~wr_en & (~out_valid | out_ready).
- States: IDLE, GATHER.
  - IDLE, accept with rot0/rot180: read row sy (one row); the mapped line is loaded into line_data on the accept edge; out_valid←1; stay IDLE.
  - IDLE, accept with rot90/rot270: latch sprite/line/orient; cnt←0; go GATHER.
  - GATHER, each cycle with wr_en=0: read row cnt; write the pixel it supplies into the accumulator; cnt++.
  - GATHER, cycle with cnt==N and wr_en=0: load accumulator result into line_data; out_valid←1; go IDLE.
  - GATHER, cycle with wr_en=1: the write happens, the gather step stalls, cnt holds.
- Writes always win the single store port. A write to a row not yet gathered is visible in the result; a write to an already-read row is not.
- req_sprite ≥ NUM_SPRITES: line_data = all ones, with the same latency and path as an in-range request.
- out_valid clears on an edge with out_ready=1 and no new load. line_data holds while out_valid & ~out_ready.

## Timing
- Reset (async assert): state=IDLE, cnt=0, out_valid=0, line_data=all ones, busy=0, all mem rows all ones. req_ready follows its equation after reset.
- rot0/rot180: out_valid high after the accept edge (latency 1). Back-to-back accepts are possible every cycle while out_ready=1.
- rot90/rot270: out_valid high after accept edge + SPRITE_W edges, plus one edge per stalling write. req_ready is low throughout GATHER.
- Reset mid-GATHER: the request is abandoned and nothing is output.

## Test plan
- Load sprite 0 rows C7,83,81,C0,C8,91,83,C7; request line 3, orient 0 → line_data=0x03, out_valid one edge after accept; orient 4 (mirror), line 3 → 0xC0.
- Sprite 2 all FF except row1=0xBF:
  - orient 1, line 1 → 0xBF, out_valid exactly 8 edges after accept, busy high for those 8 cycles
  - orient 3, line 6 → 0xFD
  - orient 2, line 6 → 0xBF
- Backpressure: hold out_ready=0 after a result → line_data and out_valid stable, req_ready=0; raise out_ready with a new rot0 request pending → accepted the same edge, new data next cycle.
- Write collision: during an orient-1 gather, pulse wr_en 2 cycles on rows not yet read (set them to 0x00) → result reflects the new rows, latency 10. wr_en in IDLE forces req_ready=0.
- req_sprite=15 with NUM_SPRITES=9 → 0xFF with normal latency. Out-of-range write leaves all rows unchanged.
- Assert reset at gather cycle 4 → out_valid=0, busy=0, all rows read 0xFF afterwards, next request completes normally.
